// File: rtl/uart_mem_loader_if.sv
// Memory-write and status bundle driven by the UART loader toward a word memory.
// master drives the one-cycle write strobe, address/data and status flags; slave observes them.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 2,
  parameter int WORD_W = 32
);
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [WORD_W-1:0] o_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_frame_err;

  modport master (
    output o_we, o_addr, o_wdata, o_busy, o_done, o_frame_err
  );

  modport slave (
    input  o_we, o_addr, o_wdata, o_busy, o_done, o_frame_err
  );
endinterface

// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver packing little-endian bytes into DEPTH memory words; o_we one cycle after the completing stop sample.
// No backpressure: the line is free-running. LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_W       = 32,
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rxd,
  uart_mem_loader_if.master bus
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic               rxd_s1, rxd_s2, rxd_prev;
  logic [CNT_W-1:0]   clk_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         rx_sr;
  logic [WORD_W-1:0]  word_sr, word_nxt;
  logic [IDX_W-1:0]   byte_idx;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               full;
  logic               fall;
  logic               cnt_clr, shift_en, byte_ok, stop_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= i_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  // Edge needs a high sample first, so a line stuck low after a bad stop never re-arms.
  assign fall = rxd_prev & ~rxd_s2;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_nxt = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rxd_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_FULL) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
          if (rxd_s2) byte_ok  = 1'b1;
          else        stop_err = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_comb begin
    word_nxt = word_sr;
    for (int b = 0; b < BYTES; b++) begin
      if (byte_idx == IDX_W'(b)) word_nxt[b*8 +: 8] = rx_sr;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_sr           <= '0;
      word_sr         <= '0;
      byte_idx        <= '0;
      wr_ptr          <= '0;
      full            <= 1'b0;
      bus.o_we        <= 1'b0;
      bus.o_addr      <= '0;
      bus.o_wdata     <= '0;
      bus.o_done      <= 1'b0;
      bus.o_frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum            <= '0;
`endif
    end else begin
      bus.o_we <= 1'b0;
      if (shift_en) rx_sr <= {rxd_s2, rx_sr[7:1]};
      if (stop_err) bus.o_frame_err <= 1'b1;
      if (byte_ok && !full) begin
        word_sr <= word_nxt;
        if (byte_idx == LAST_IDX) begin
          byte_idx    <= '0;
          bus.o_we    <= 1'b1;
          bus.o_addr  <= wr_ptr;
          bus.o_wdata <= word_nxt;
          if (wr_ptr == LAST_ADDR) full   <= 1'b1;
          else                     wr_ptr <= wr_ptr + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (byte_ok && !full) csum <= csum + rx_sr;
      if (byte_ok && full && !bus.o_done) begin
        bus.o_done <= 1'b1;
        if (rx_sr != csum) bus.o_frame_err <= 1'b1;
      end
`else
      // Last strobe is the only o_we seen with full set; done rises as it drops.
      if (bus.o_we && full) bus.o_done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader (CLKS_PER_BIT=16, WORD_W=32, DEPTH=4).
module tb_uart_mem_loader;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] wq_data[$];
  logic [31:0] wq_addr[$];
  int          we_long = 0;
  logic        we_prev = 1'b0;
  logic        last_pending = 1'b0;
  logic        done_at_last = 1'b0;
  logic        done_after_last = 1'b0;
  logic        busy_seen = 1'b0;

  uart_mem_loader_if #(.ADDR_W(2), .WORD_W(32)) bus ();

  uart_mem_loader #(.CLKS_PER_BIT(BIT), .WORD_W(32), .DEPTH(4), .ADDR_W(2)) dut (
    .i_clk  (clk),
    .i_nrst (rst_n),
    .i_rxd  (rxd),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (last_pending) begin
      done_after_last = bus.o_done;
      last_pending = 1'b0;
    end
    if (bus.o_we) begin
      wq_data.push_back(bus.o_wdata);
      wq_addr.push_back(32'(bus.o_addr));
      if (we_prev) we_long++;
      if (bus.o_addr == 2'd3) begin
        done_at_last = bus.o_done;
        last_pending = 1'b1;
      end
    end
    if (bus.o_busy) busy_seen = 1'b1;
    we_prev = bus.o_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idle);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    if (idle > 0) begin
      rxd = 1'b1;
      repeat (idle) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wq_data.delete();
    wq_addr.delete();
    we_long = 0;
    busy_seen = 1'b0;
    done_at_last = 1'b0;
    done_after_last = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_we",   32'(bus.o_we), 32'd0);
    check("rst_addr", 32'(bus.o_addr), 32'd0);
    check("rst_data", bus.o_wdata, 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_ferr", 32'(bus.o_frame_err), 32'd0);

    // One word
    do_reset();
    send_byte(8'h78, 1'b1, BIT);
    send_byte(8'h56, 1'b1, BIT);
    send_byte(8'h34, 1'b1, BIT);
    send_byte(8'h12, 1'b1, BIT);
    check("w1_count", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() > 0) begin
      check("w1_addr", wq_addr[0], 32'd0);
      check("w1_data", wq_data[0], 32'h12345678);
    end
    check("w1_done", 32'(bus.o_done), 32'd0);
    check("w1_hold_data", bus.o_wdata, 32'h12345678);
    check("w1_hold_we", 32'(bus.o_we), 32'd0);

    // Glitch: 4-cycle low pulse
    do_reset();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("gl_busy_seen", 32'(busy_seen), 32'd1);
    check("gl_busy", 32'(bus.o_busy), 32'd0);
    check("gl_ferr", 32'(bus.o_frame_err), 32'd0);
    check("gl_writes", 32'(wq_data.size()), 32'd0);

    // Bad stop bit, line held low, then a clean word
    do_reset();
    send_byte(8'hAA, 1'b0, 0);
    repeat (40) @(negedge clk);
    check("fe_busy_low", 32'(bus.o_busy), 32'd0);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    check("fe_ferr_set", 32'(bus.o_frame_err), 32'd1);
    send_byte(8'h11, 1'b1, BIT);
    send_byte(8'h22, 1'b1, BIT);
    send_byte(8'h33, 1'b1, BIT);
    send_byte(8'h44, 1'b1, BIT);
    check("fe_count", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() > 0) begin
      check("fe_addr", wq_addr[0], 32'd0);
      check("fe_data", wq_data[0], 32'h44332211);
    end
    check("fe_ferr", 32'(bus.o_frame_err), 32'd1);

    // Reset mid-word and mid-frame
    do_reset();
    send_byte(8'h55, 1'b1, BIT);
    send_byte(8'h66, 1'b1, BIT);
    rxd = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    do_reset();
    check("rs_ferr", 32'(bus.o_frame_err), 32'd0);
    for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i), 1'b1, BIT);
    check("rs_count", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() > 0) begin
      check("rs_addr", wq_addr[0], 32'd0);
      check("rs_data", wq_data[0], 32'hA4A3A2A1);
    end

    // Full load of 16 bytes
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, BIT);
`ifdef LOADER_CHECKSUM_EN
    check("fl_done_pre", 32'(bus.o_done), 32'd0);
    send_byte(8'h78, 1'b1, BIT);
`else
    check("fl_done_with_we", 32'(done_at_last), 32'd0);
    check("fl_done_after_we", 32'(done_after_last), 32'd1);
`endif
    check("fl_count", 32'(wq_data.size()), 32'd4);
    if (wq_data.size() == 4) begin
      check("fl_a0", wq_addr[0], 32'd0);
      check("fl_d0", wq_data[0], 32'h03020100);
      check("fl_a1", wq_addr[1], 32'd1);
      check("fl_d1", wq_data[1], 32'h07060504);
      check("fl_a2", wq_addr[2], 32'd2);
      check("fl_d2", wq_data[2], 32'h0B0A0908);
      check("fl_a3", wq_addr[3], 32'd3);
      check("fl_d3", wq_data[3], 32'h0F0E0D0C);
    end
    check("fl_we_len", 32'(we_long), 32'd0);
    check("fl_done", 32'(bus.o_done), 32'd1);
    check("fl_ferr", 32'(bus.o_frame_err), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h99, 1'b1, BIT);
    check("fl_no_more_writes", 32'(wq_data.size()), 32'd4);
    check("fl_done_sticky", 32'(bus.o_done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    check("cs_done", 32'(bus.o_done), 32'd1);
    check("cs_ferr", 32'(bus.o_frame_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: i_clk cycles per UART bit; SHALL be >= 4.
REQ-002 Parameter WORD_W, default 32: memory word width; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 4: number of words to load.
REQ-004 Parameter ADDR_W, default 2: address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-005 i_clk  input  1  single clock; all flops on rising edge.
REQ-006 i_nrst  input  1  reset, asynchronous assert, active-low.
REQ-007 i_rxd  input  1  UART serial line, 8N1, idle high, asynchronous to i_clk.
REQ-008 o_we  output  1  memory write strobe, one-cycle pulse.
REQ-009 o_addr  output  ADDR_W  word address for o_we.
REQ-010 o_wdata  output  WORD_W  word data for o_we.
REQ-011 o_busy  output  1  high while a frame is being received (state != IDLE).
REQ-012 o_done  output  1  high once DEPTH words have been written; sticky.
REQ-013 o_frame_err  output  1  sticky error flag (stop-bit error, or checksum error per REQ-031).

Function
REQ-014 i_rxd SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
REQ-015 RX FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a synchronized falling edge; bit counter cleared.
REQ-017 START: wait CLKS_PER_BIT/2 cycles, sample; if 1 -> IDLE (glitch, no byte, no error); if 0 -> DATA.
REQ-018 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; after bit 7 -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; if 1 the byte is valid; if 0, discard the byte, set o_frame_err. Both cases -> IDLE.
REQ-020 IDLE SHALL not re-arm until the synchronized line has been seen high for at least one cycle; a line held low after a frame error SHALL NOT start a new frame.
REQ-021 Word assembly is little-endian: the first valid byte of a word goes to bits [7:0]; WORD_W/8 bytes make one word.
REQ-022 o_we SHALL pulse exactly one cycle, in the cycle after the STOP sample that completes a word; o_addr/o_wdata are valid in that same cycle.
REQ-023 o_addr SHALL start at 0 and increment by 1 after each write; the first word goes to address 0.
REQ-024 After the write to address DEPTH-1, o_done SHALL be set on the same edge that drops o_we; further bytes are decoded but produce no writes.
REQ-025 A discarded byte (REQ-019) SHALL NOT advance the byte counter; a partial word is kept.
REQ-026 o_addr and o_wdata SHALL hold their last-written value between strobes.

Reset
REQ-027 While i_nrst=0: FSM=IDLE, synchronizer=1, counters=0, o_we=0, o_addr=0, o_wdata=0, o_busy=0, o_done=0, o_frame_err=0.
REQ-028 Reset mid-frame or mid-word SHALL abandon the partial byte and word; the first valid byte after release starts word 0, bits [7:0].

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN selects the checksum feature.
REQ-030 Without LOADER_CHECKSUM_EN: o_done is set per REQ-024.
REQ-031 With LOADER_CHECKSUM_EN: after the last word, one more valid byte is expected; o_done is set when it arrives. If it differs from the 8-bit modulo-256 sum of all data bytes, o_frame_err SHALL also be set.

Verification (CLKS_PER_BIT=16, WORD_W=32, DEPTH=4)
REQ-032 Send 0x78,0x56,0x34,0x12 -> one o_we, o_addr=0, o_wdata=0x12345678, o_done=0.
REQ-033 Send 16 bytes 0x00..0x0F -> writes 0x03020100@0, 0x07060504@1, 0x0B0A0908@2, 0x0F0E0D0C@3; o_done=1 (with the macro, add a trailing byte 0x78 first).
REQ-034 Low pulse of 4 cycles on i_rxd -> no byte, o_busy returns to 0, o_frame_err=0.
REQ-035 Frame 0xAA with stop bit 0, then 0x11,0x22,0x33,0x44 -> o_frame_err=1; single write 0x44332211@0.
REQ-036 Assert i_nrst after 2 bytes, release, send 4 bytes 0xA1..0xA4 -> write 0xA4A3A2A1@0.
REQ-037 With LOADER_CHECKSUM_EN: 16 bytes 0x00..0x0F, then 0x00 -> o_done=1, o_frame_err=1.
